// File: rtl/mem_port_arb.sv
// Two-requester memory port arbiter with a fixed-latency access FSM.
// Requester 0 is the CPU, requester 1 is the DMA/loader. Each grant runs
// IDLE -> ACCESS (WAIT+1 cycles) -> DONE, or IDLE -> DONE with err set for a
// misaligned address.
// Optional feature: define MEM_PORT_ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise requester 0 always wins.
module mem_port_arb #(
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt_q, gnt_d;    // requester owning the access in flight
  logic        err_q, err_d;

  logic        gnt_sel;         // requester chosen if a grant happens now
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

`ifdef MEM_PORT_ARB_RR_EN
  logic        ptr_q, ptr_d;    // preferred requester on a tie

  // Tie goes to the requester not granted last.
  always_comb begin
    if (m0_req && m1_req) begin
      gnt_sel = ptr_q;
    end else begin
      gnt_sel = !m0_req;
    end
  end
`else
  // Fixed priority: requester 0 wins any tie.
  always_comb begin
    gnt_sel = !m0_req;
  end
`endif

  // Field mux for the selected requester.
  always_comb begin
    sel_we    = gnt_sel ? m1_we    : m0_we;
    sel_addr  = gnt_sel ? m1_addr  : m0_addr;
    sel_wdata = gnt_sel ? m1_wdata : m0_wdata;
  end

  // Next-state logic for the access FSM and its latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
`ifdef MEM_PORT_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          gnt_d   = gnt_sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = 4'(WAIT);
          err_d   = (sel_addr[1:0] != 2'b00);
          // Misaligned accesses never touch the memory.
          state_d = (sel_addr[1:0] != 2'b00) ? StDone : StAccess;
`ifdef MEM_PORT_ARB_RR_EN
          ptr_d   = !gnt_sel;
`endif
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_PORT_ARB_RR_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Outputs decode from registered state only.
  always_comb begin
    mem_ce    = (state_q == StAccess);
    mem_we    = (state_q == StAccess) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    m0_done   = (state_q == StDone) && !gnt_q;
    m1_done   = (state_q == StDone) && gnt_q;
    m0_err    = (state_q == StDone) && !gnt_q && err_q;
    m1_err    = (state_q == StDone) && gnt_q && err_q;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: instance a uses WAIT=0, instance b WAIT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
  logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
  logic a_m0_done, a_m0_err, a_m1_done, a_m1_err, a_mem_ce, a_mem_we;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;

  logic b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
  logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
  logic b_m0_done, b_m0_err, b_m1_done, b_m1_err, b_mem_ce, b_mem_we;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.WAIT(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_done(a_m0_done), .m0_err(a_m0_err),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_done(a_m1_done), .m1_err(a_m1_err),
    .rdata(a_rdata), .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arb #(.WAIT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_done(b_m0_done), .m0_err(b_m0_err),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_done(b_m1_done), .m1_err(b_m1_err),
    .rdata(b_rdata), .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    logic [9:0] outs;
    @(negedge clk);
    outs = {a_m0_done, a_m0_err, a_m1_done, a_m1_err, a_mem_ce,
            b_m0_done, b_m0_err, b_m1_done, b_m1_err, b_mem_ce};
    n_checks++;
    if (outs !== 10'd0) $display("FAIL reset_flags: got %b want 0", outs);
    else n_pass++;
    n_checks++;
    if ({a_rdata, a_mem_addr, b_rdata, b_mem_wdata} !== 128'd0)
      $display("FAIL reset_data: got %h %h %h %h want 0", a_rdata, a_mem_addr, b_rdata,
               b_mem_wdata);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  // WAIT=0 read: ACCESS in cycle 1, done in cycle 2.
  task automatic test_read_wait0();
    @(negedge clk);
    mem_rdata = 32'hDEADBEEF;
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if ({a_mem_ce, a_mem_we, a_m0_done} !== 3'b100 || a_mem_addr !== 32'h100)
      $display("FAIL rd0_access: ce/we/done=%b%b%b addr=%h want 100 addr=100",
               a_mem_ce, a_mem_we, a_m0_done, a_mem_addr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({a_m0_done, a_m0_err, a_m1_done, a_mem_ce} !== 4'b1000)
      $display("FAIL rd0_done: done/err/m1done/ce=%b%b%b%b want 1000",
               a_m0_done, a_m0_err, a_m1_done, a_mem_ce);
    else n_pass++;
    n_checks++;
    if (a_rdata !== 32'hDEADBEEF) $display("FAIL rd0_rdata: got %h want deadbeef", a_rdata);
    else n_pass++;
    a_m0_req = 0;
    @(negedge clk);
    n_checks++;
    if ({a_m0_done, a_mem_ce} !== 2'b00)
      $display("FAIL rd0_after: done/ce=%b%b want 00", a_m0_done, a_mem_ce);
    else n_pass++;
  endtask

  // Misaligned address: straight to DONE with err, memory untouched.
  task automatic test_misaligned();
    @(negedge clk);
    mem_rdata = 32'h11111111;
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h102;
    @(negedge clk);
    n_checks++;
    if ({a_m0_done, a_m0_err, a_m1_done, a_m1_err, a_mem_ce} !== 5'b11000)
      $display("FAIL mis_done: done/err/m1done/m1err/ce=%b%b%b%b%b want 11000",
               a_m0_done, a_m0_err, a_m1_done, a_m1_err, a_mem_ce);
    else n_pass++;
    n_checks++;
    if (a_rdata !== 32'hDEADBEEF) $display("FAIL mis_rdata: got %h want deadbeef", a_rdata);
    else n_pass++;
    a_m0_req = 0;
    @(negedge clk);
    n_checks++;
    if ({a_m0_done, a_m0_err, a_mem_ce} !== 3'b000)
      $display("FAIL mis_after: done/err/ce=%b%b%b want 000", a_m0_done, a_m0_err, a_mem_ce);
    else n_pass++;
  endtask

  // WAIT=3: a read, then a write whose fields change mid-flight.
  task automatic test_write_wait3();
    int ce_cnt, done_cnt, done_at, m0_cnt;
    ce_cnt = 0; done_cnt = 0; done_at = 0;
    @(negedge clk);
    mem_rdata = 32'hA5A55A5A;
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h200;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b_mem_ce) ce_cnt++;
      if (b_m0_done) begin done_cnt++; done_at = i; b_m0_req = 0; end
    end
    n_checks++;
    if (ce_cnt !== 4 || done_cnt !== 1 || done_at !== 5)
      $display("FAIL rd3_timing: ce=%0d done=%0d at=%0d want 4 1 5", ce_cnt, done_cnt, done_at);
    else n_pass++;
    n_checks++;
    if (b_rdata !== 32'hA5A55A5A) $display("FAIL rd3_rdata: got %h want a5a55a5a", b_rdata);
    else n_pass++;

    ce_cnt = 0; done_cnt = 0; done_at = 0; m0_cnt = 0;
    mem_rdata = 32'hFFFF0000;
    b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'h40; b_m1_wdata = 32'h12345678;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) begin b_m1_addr = 32'h80; b_m1_wdata = 32'h0; end
      if (b_mem_ce) begin
        ce_cnt++;
        n_checks++;
        if (b_mem_we !== 1'b1 || b_mem_addr !== 32'h40 || b_mem_wdata !== 32'h12345678)
          $display("FAIL wr3_bus: we=%b addr=%h data=%h want 1 40 12345678",
                   b_mem_we, b_mem_addr, b_mem_wdata);
        else n_pass++;
      end else begin
        n_checks++;
        if (b_mem_we !== 1'b0) $display("FAIL wr3_we_idle: got %b want 0", b_mem_we);
        else n_pass++;
      end
      if (b_m0_done) m0_cnt++;
      if (b_m1_done) begin done_cnt++; done_at = i; b_m1_req = 0; end
    end
    n_checks++;
    if (ce_cnt !== 4 || done_cnt !== 1 || done_at !== 5 || m0_cnt !== 0)
      $display("FAIL wr3_timing: ce=%0d done=%0d at=%0d m0done=%0d want 4 1 5 0",
               ce_cnt, done_cnt, done_at, m0_cnt);
    else n_pass++;
    n_checks++;
    if (b_rdata !== 32'hA5A55A5A) $display("FAIL wr3_rdata: got %h want a5a55a5a", b_rdata);
    else n_pass++;
    n_checks++;
    if (b_mem_addr !== 32'h40) $display("FAIL wr3_addr_hold: got %h want 40", b_mem_addr);
    else n_pass++;
  endtask

  // Reset during the second ACCESS cycle aborts the access.
  task automatic test_reset_mid_access();
    int done_cnt, done_at;
    done_cnt = 0; done_at = 0;
    @(negedge clk);
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h300;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 0;
    b_m0_req = 0;
    #1;
    n_checks++;
    if ({b_mem_ce, b_mem_we, b_m0_done, b_m1_done} !== 4'b0000)
      $display("FAIL rst_async_flags: ce/we/d0/d1=%b%b%b%b want 0000",
               b_mem_ce, b_mem_we, b_m0_done, b_m1_done);
    else n_pass++;
    n_checks++;
    if (b_rdata !== 32'd0 || b_mem_addr !== 32'd0)
      $display("FAIL rst_async_data: rdata=%h addr=%h want 0 0", b_rdata, b_mem_addr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_m0_done || b_m1_done) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) $display("FAIL rst_no_done: got %0d want 0", done_cnt);
    else n_pass++;
    done_cnt = 0;
    mem_rdata = 32'h0BADF00D;
    b_m1_req = 1; b_m1_we = 0; b_m1_addr = 32'h44;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b_m1_done) begin done_cnt++; done_at = i; b_m1_req = 0; end
    end
    n_checks++;
    if (done_cnt !== 1 || done_at !== 5)
      $display("FAIL rst_next_req: done=%0d at=%0d want 1 5", done_cnt, done_at);
    else n_pass++;
    n_checks++;
    if (b_rdata !== 32'h0BADF00D) $display("FAIL rst_next_rdata: got %h want 0badf00d", b_rdata);
    else n_pass++;
  endtask

  // Both requesters hold req continuously on the WAIT=0 instance.
  task automatic test_arbitration();
    logic order [4];
    int n_done, m1_cnt, both;
    logic [3:0] got, want;
    n_done = 0; m1_cnt = 0; both = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    mem_rdata = 32'h0;
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_m0_done && a_m1_done) both++;
      if (a_m1_done) m1_cnt++;
      if (a_m0_done || a_m1_done) begin
        if (n_done < 4) order[n_done] = a_m1_done;
        n_done++;
      end
    end
    a_m0_req = 0; a_m1_req = 0;
    n_checks++;
    if (n_done !== 4 || both !== 0)
      $display("FAIL arb_count: dones=%0d both=%0d want 4 0", n_done, both);
    else n_pass++;
    got = {order[0], order[1], order[2], order[3]};
`ifdef MEM_PORT_ARB_RR_EN
    want = 4'b0101;
    n_checks++;
    if (m1_cnt !== 2) $display("FAIL arb_rr_m1: got %0d want 2", m1_cnt);
    else n_pass++;
`else
    want = 4'b0000;
    n_checks++;
    if (m1_cnt !== 0) $display("FAIL arb_fixed_m1: got %0d want 0", m1_cnt);
    else n_pass++;
`endif
    n_checks++;
    if (got !== want) $display("FAIL arb_order: got %b want %b", got, want);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_wait0();
    test_misaligned();
    test_write_wait3();
    test_reset_mid_access();
    test_arbitration();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
